// File: rtl/ram.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : ram                                                          |
// | Purpose  : simple dual-port synchronous RAM, one write and one read     |
// |            port on a shared clock, registered read data.                |
// | Options  : RAM_BYPASS_EN - write-first on same-address collisions       |
// |            (default is read-first, returning the old contents).         |
// | Revision : 1.0 - initial release                                        |
// +-------------------------------------------------------------------------+
module ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  // Zero power-up image; maps onto the block-RAM init contents.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

  logic w_write_en;
  logic w_read_en;

  assign w_write_en = write_enable & ~rst;
  assign w_read_en  = read_enable;

  always_ff @(posedge clk) begin
    if (w_write_en) begin
      r_mem[write_addr] <= write_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
    end else if (w_read_en) begin
`ifdef RAM_BYPASS_EN
      if (w_write_en && (write_addr == read_addr)) begin
        read_data <= write_data;
      end else begin
        read_data <= r_mem[read_addr];
      end
`else
      // Non-blocking write above means this samples the pre-write word.
      read_data <= r_mem[read_addr];
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram.sv
`default_nettype none
// Self-checking bench for ram: vector table, reset sequence and random soak
// against a reference memory model, with a queue of expected read results.
module tb_ram;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

`ifdef RAM_BYPASS_EN
  localparam logic [DW-1:0] COLLIDE_EXP = 16'h00FF;
  localparam bit            BYPASS      = 1'b1;
`else
  localparam logic [DW-1:0] COLLIDE_EXP = 16'h0001;
  localparam bit            BYPASS      = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] write_data;
  logic          write_enable;
  logic [AW-1:0] write_addr;
  logic          read_enable;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data;

  always #5 clk = ~clk;

  ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .write_data   (write_data),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .read_enable  (read_enable),
    .read_addr    (read_addr),
    .read_data    (read_data)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] last;
  logic [DW-1:0] exp_q [$];
  vec_t          vecs [15];

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: read_data=%h expected=%h", nm, act, exp);
    end
  endtask

  // Drive one cycle, queue its expected output, compare after the edge.
  task automatic drive(input string nm, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                       input logic [DW-1:0] exp);
    logic [DW-1:0] e;
    write_enable = we;
    write_addr   = wa;
    write_data   = wd;
    read_enable  = re;
    read_addr    = ra;
    exp_q.push_back(exp);
    if (we) model[wa] = wd;
    last = exp;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = exp_q.pop_front();
      check(nm, read_data, e);
    end
  endtask

  function automatic logic [DW-1:0] model_exp(input logic we, input logic [AW-1:0] wa,
                                              input logic [DW-1:0] wd, input logic re,
                                              input logic [AW-1:0] ra);
    if (!re) return last;
    if (BYPASS && we && (wa == ra)) return wd;
    return model[ra];
  endfunction

  initial begin
    logic          we, re;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;

    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    last = '0;

    //           we    wa       wd        re    ra       exp
    vecs[0]  = '{1'b1, 10'd5,    16'hBEEF, 1'b0, 10'd0,    16'h0000};
    vecs[1]  = '{1'b0, 10'd0,    16'h0000, 1'b1, 10'd5,    16'hBEEF};
    vecs[2]  = '{1'b0, 10'd0,    16'h0000, 1'b0, 10'd100,  16'hBEEF};
    vecs[3]  = '{1'b0, 10'd0,    16'h0000, 1'b0, 10'd200,  16'hBEEF};
    vecs[4]  = '{1'b0, 10'd0,    16'h0000, 1'b0, 10'd300,  16'hBEEF};
    vecs[5]  = '{1'b1, 10'd7,    16'h0001, 1'b0, 10'd7,    16'hBEEF};
    vecs[6]  = '{1'b1, 10'd7,    16'h00FF, 1'b1, 10'd7,    COLLIDE_EXP};
    vecs[7]  = '{1'b0, 10'd7,    16'h0000, 1'b1, 10'd7,    16'h00FF};
    vecs[8]  = '{1'b1, 10'd0,    16'hFFFF, 1'b0, 10'd0,    16'h00FF};
    vecs[9]  = '{1'b1, 10'd1023, 16'hA5A5, 1'b0, 10'd0,    16'h00FF};
    vecs[10] = '{1'b0, 10'd0,    16'h0000, 1'b1, 10'd0,    16'hFFFF};
    vecs[11] = '{1'b0, 10'd0,    16'h0000, 1'b1, 10'd1023, 16'hA5A5};
    vecs[12] = '{1'b0, 10'd0,    16'h0000, 1'b1, 10'd512,  16'h0000};
    vecs[13] = '{1'b1, 10'd3,    16'h1111, 1'b1, 10'd1023, 16'hA5A5};
    vecs[14] = '{1'b0, 10'd0,    16'h0000, 1'b1, 10'd3,    16'h1111};

    rst = 1'b1;
    write_enable = 1'b0;
    write_addr = '0;
    write_data = '0;
    read_enable = 1'b0;
    read_addr = '0;
    #1;
    check("reset_state", read_data, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive($sformatf("vec%0d", i), vecs[i].we, vecs[i].wa, vecs[i].wd,
            vecs[i].re, vecs[i].ra, vecs[i].exp);
    end

    // Asynchronous reset mid-run, memory retained across it.
    drive("pre_rst_wr", 1'b1, 10'd9, 16'h1234, 1'b0, 10'd0, 16'h1111);
    drive("pre_rst_rd", 1'b0, 10'd0, 16'h0000, 1'b1, 10'd9, 16'h1234);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", read_data, 16'h0000);
    write_enable = 1'b1;
    write_addr   = 10'd9;
    write_data   = 16'hDEAD;
    read_enable  = 1'b1;
    read_addr    = 10'd9;
    @(posedge clk);
    #1;
    check("rst_hold", read_data, 16'h0000);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    rst = 1'b0;
    last = '0;
    drive("post_rst_rd", 1'b0, 10'd0, 16'h0000, 1'b1, 10'd9, 16'h1234);

    // Random soak; narrow address range some of the time to force collisions.
    for (int n = 0; n < 1000; n++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wd = DW'($urandom);
      if (n % 2 == 0) begin
        wa = AW'($urandom_range(0, 7));
        ra = AW'($urandom_range(0, 7));
      end else begin
        wa = AW'($urandom);
        ra = AW'($urandom);
      end
      drive("soak", we, wa, wd, re, ra, model_exp(we, wa, wd, re, ra));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
